legv8_multicycle_ctrl: RTL

- Multi-cycle main controller for the LEGv8 core.
- Sequences fetch, decode, execute, memory and write-back over several cycles using one shared ALU, one shared memory port and one instruction register.
- Generates the 2-bit ALUop that feeds the ALU control decoder, plus all datapath mux, enable and memory-handshake strobes.
- Waits on a ready handshake from memory with variable latency.

---
 rtl/legv8_pkg.sv | 73 +++++++
 rtl/legv8_multicycle_ctrl_if.sv | 40 ++++
 rtl/legv8_op_classify.sv | 25 ++
 rtl/legv8_multicycle_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle controller:
// FSM states, opcode classes, opcode match patterns and datapath select codes.
package legv8_pkg;

  localparam int unsigned OPCODE_W = 11;
  localparam int unsigned STATE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_R_WB     = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WB   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_FAULT    = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    OP_RTYPE   = 3'd0,
    OP_LDUR    = 3'd1,
    OP_STUR    = 3'd2,
    OP_CBZ     = 3'd3,
    OP_B       = 3'd4,
    OP_ILLEGAL = 3'd5
  } op_class_e;

  localparam logic [OPCODE_W-1:0] OPC_ADD  = 11'b10001011000;
  localparam logic [OPCODE_W-1:0] OPC_SUB  = 11'b11001011000;
  localparam logic [OPCODE_W-1:0] OPC_AND  = 11'b10001010000;
  localparam logic [OPCODE_W-1:0] OPC_ORR  = 11'b10101010000;
  localparam logic [OPCODE_W-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [OPCODE_W-1:0] OPC_STUR = 11'b11111000000;

  // CBZ and B carry immediate bits in the low opcode field; match under mask
  localparam logic [OPCODE_W-1:0] OPC_CBZ  = 11'b10110100000;
  localparam logic [OPCODE_W-1:0] OPM_CBZ  = 11'b11111111000;
  localparam logic [OPCODE_W-1:0] OPC_B    = 11'b00010100000;
  localparam logic [OPCODE_W-1:0] OPM_B    = 11'b11111100000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASS  = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] ALU_B_REG  = 2'b00;
  localparam logic [1:0] ALU_B_FOUR = 2'b01;
  localparam logic [1:0] ALU_B_IMM  = 2'b10;
  localparam logic [1:0] ALU_B_BR   = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg2loc;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface legv8_multicycle_ctrl_if;
  import legv8_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic                pc_write;
  logic                pc_write_cond;
  logic [1:0]          pc_source;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                reg2loc;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                mem_to_reg;
  logic                reg_write;
  logic                instr_done;
  logic                fault;
  logic [STATE_W-1:0]  state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg2loc, alu_src_a, alu_src_b, alu_op, mem_to_reg,
           reg_write, instr_done, fault, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg2loc, alu_src_a, alu_src_b, alu_op, mem_to_reg,
           reg_write, instr_done, fault, state_dbg
  );

endinterface

// File: rtl/legv8_op_classify.sv
// Combinational opcode classifier: instruction[31:21] -> instruction class.
module legv8_op_classify
  import legv8_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  output op_class_e           o_class_c
);

  always_comb begin
    o_class_c = OP_ILLEGAL;
    if (i_opcode == OPC_ADD || i_opcode == OPC_SUB ||
        i_opcode == OPC_AND || i_opcode == OPC_ORR) begin
      o_class_c = OP_RTYPE;
    end else if (i_opcode == OPC_LDUR) begin
      o_class_c = OP_LDUR;
    end else if (i_opcode == OPC_STUR) begin
      o_class_c = OP_STUR;
    end else if ((i_opcode & OPM_CBZ) == OPC_CBZ) begin
      o_class_c = OP_CBZ;
    end else if ((i_opcode & OPM_B) == OPC_B) begin
      o_class_c = OP_B;
    end
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multi-cycle main controller: sequences fetch/decode/execute/memory/
// write-back over a shared ALU and memory port, with a memory-wait watchdog.
module legv8_multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  legv8_multicycle_ctrl_if.master ctrl_bus
);

  state_e           r_state;
  ctrl_t            r_ctrl;
  logic             r_fault;
  logic [CNT_W-1:0] r_cnt;

  state_e           w_next;
  op_class_e        w_cls;
  logic             w_req;
  logic             w_done;
  logic             w_wait;
  logic             w_timeout;
  logic             w_fetch_done;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_unused_zero;

  legv8_op_classify u_classify (
    .i_opcode  (ctrl_bus.opcode),
    .o_class_c (w_cls)
  );

  // Strobe set for the state being entered; registered so it aligns with r_state
  function automatic ctrl_t state_ctrl(input state_e s, input op_class_e c);
    ctrl_t v;
    v = '0;
    case (s)
      ST_FETCH: begin
        v.mem_read  = 1'b1;
        v.alu_src_b = ALU_B_FOUR;
        v.alu_op    = ALUOP_ADD;
        v.pc_source = PC_SRC_ALU;
      end
      ST_DECODE: begin
        v.alu_src_b = ALU_B_BR;
        v.alu_op    = ALUOP_ADD;
      end
      ST_EXEC_R: begin
        v.alu_src_a = 1'b1;
        v.alu_src_b = ALU_B_REG;
        v.alu_op    = ALUOP_RTYPE;
      end
      ST_R_WB: begin
        v.reg_write  = 1'b1;
        v.instr_done = 1'b1;
      end
      ST_MEM_ADDR: begin
        v.alu_src_a = 1'b1;
        v.alu_src_b = ALU_B_IMM;
        v.alu_op    = ALUOP_ADD;
        v.reg2loc   = (c == OP_STUR);
      end
      ST_MEM_RD: begin
        v.mem_read = 1'b1;
        v.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        v.reg_write  = 1'b1;
        v.mem_to_reg = 1'b1;
        v.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        v.mem_write = 1'b1;
        v.i_or_d    = 1'b1;
        v.reg2loc   = 1'b1;
      end
      ST_BRANCH: begin
        v.reg2loc       = 1'b1;
        v.alu_src_a     = 1'b1;
        v.alu_src_b     = ALU_B_REG;
        v.alu_op        = ALUOP_PASS;
        v.pc_write_cond = 1'b1;
        v.pc_source     = PC_SRC_ALUOUT;
        v.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        v.pc_write   = 1'b1;
        v.pc_source  = PC_SRC_JUMP;
        v.instr_done = 1'b1;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Memory handshake only counts while a request is actually being driven
  assign w_req     = r_ctrl.mem_read | r_ctrl.mem_write;
  assign w_done    = w_req & ctrl_bus.mem_ready;
  assign w_wait    = w_req & ~ctrl_bus.mem_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (MEM_WAIT_MAX != 0) && w_wait && (w_cnt_inc == CNT_W'(MEM_WAIT_MAX));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_done)         w_next = ST_DECODE;
        else if (w_timeout) w_next = ST_FAULT;
      end
      ST_DECODE: begin
        case (w_cls)
          OP_RTYPE:         w_next = ST_EXEC_R;
          OP_LDUR, OP_STUR: w_next = ST_MEM_ADDR;
          OP_CBZ:           w_next = ST_BRANCH;
          OP_B:             w_next = ST_JUMP;
          default:          w_next = ST_FAULT;
        endcase
      end
      ST_EXEC_R:   w_next = ST_R_WB;
      ST_R_WB:     w_next = ST_FETCH;
      ST_MEM_ADDR: w_next = (w_cls == OP_STUR) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (w_done)         w_next = ST_MEM_WB;
        else if (w_timeout) w_next = ST_FAULT;
      end
      ST_MEM_WB:   w_next = ST_FETCH;
      ST_MEM_WR: begin
        if (w_done)         w_next = ST_FETCH;
        else if (w_timeout) w_next = ST_FAULT;
      end
      ST_BRANCH:   w_next = ST_FETCH;
      ST_JUMP:     w_next = ST_FETCH;
      ST_FAULT:    w_next = ST_FAULT;
      default:     w_next = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_ctrl  <= '0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next, w_cls);
      r_fault <= r_fault | (w_next == ST_FAULT);
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (w_wait) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  // Completion strobes must coincide with the memory's ready cycle, so they
  // are the registered request qualified by mem_ready.
  assign w_fetch_done = r_ctrl.mem_read & ~r_ctrl.i_or_d & ctrl_bus.mem_ready;

  assign ctrl_bus.ir_write      = w_fetch_done;
  assign ctrl_bus.pc_write      = r_ctrl.pc_write | w_fetch_done;
  assign ctrl_bus.instr_done    = r_ctrl.instr_done | (r_ctrl.mem_write & ctrl_bus.mem_ready);
  assign ctrl_bus.reg2loc       = r_ctrl.reg2loc |
                                  ((r_state == ST_DECODE) && (w_cls == OP_STUR || w_cls == OP_CBZ));
  assign ctrl_bus.pc_write_cond = r_ctrl.pc_write_cond;
  assign ctrl_bus.pc_source     = r_ctrl.pc_source;
  assign ctrl_bus.i_or_d        = r_ctrl.i_or_d;
  assign ctrl_bus.mem_read      = r_ctrl.mem_read;
  assign ctrl_bus.mem_write     = r_ctrl.mem_write;
  assign ctrl_bus.alu_src_a     = r_ctrl.alu_src_a;
  assign ctrl_bus.alu_src_b     = r_ctrl.alu_src_b;
  assign ctrl_bus.alu_op        = r_ctrl.alu_op;
  assign ctrl_bus.mem_to_reg    = r_ctrl.mem_to_reg;
  assign ctrl_bus.reg_write     = r_ctrl.reg_write;
  assign ctrl_bus.fault         = r_fault;
  assign ctrl_bus.state_dbg     = r_state;

  // zero gates the PC load in the datapath, not in the sequencer
  assign w_unused_zero = ctrl_bus.zero;

endmodule
